// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants and types for the ALU / mul-div unit:
//                ALUCtrl codes, funct and ALUOp encodings, engine state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALUCtrl codes driven by the decoder
    localparam logic [3:0] c_ctrl_and = 4'b0000;
    localparam logic [3:0] c_ctrl_or  = 4'b0001;
    localparam logic [3:0] c_ctrl_add = 4'b0010;
    localparam logic [3:0] c_ctrl_sub = 4'b0110;
    localparam logic [3:0] c_ctrl_slt = 4'b0111;
    localparam logic [3:0] c_ctrl_nor = 4'b1100;

    // R-type funct field values
    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_nor   = 6'b100111;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;
    localparam logic [5:0] c_fn_mult  = 6'b011000;
    localparam logic [5:0] c_fn_multu = 6'b011001;
    localparam logic [5:0] c_fn_div   = 6'b011010;
    localparam logic [5:0] c_fn_divu  = 6'b011011;

    // ALUOp encodings from the main control unit
    localparam logic [1:0] c_op_add   = 2'b00;
    localparam logic [1:0] c_op_sub   = 2'b01;
    localparam logic [1:0] c_op_funct = 2'b10;
    localparam logic [1:0] c_op_or    = 2'b11;

    // Iterative engine state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Combinational ALUOp/funct decoder. Produces the ALUCtrl code
//                and op-class flags (basic, mfhi, mflo, mul, div, signed,
//                illegal).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       is_basic,
    output logic       is_mfhi,
    output logic       is_mflo,
    output logic       is_mul,
    output logic       is_div,
    output logic       is_signed,
    output logic       is_illegal
);

    // Decode op class; funct only matters when ALUOp selects it
    always_comb begin
        alu_ctrl   = c_ctrl_add;
        is_basic   = 1'b0;
        is_mfhi    = 1'b0;
        is_mflo    = 1'b0;
        is_mul     = 1'b0;
        is_div     = 1'b0;
        is_signed  = 1'b0;
        is_illegal = 1'b0;
        case (ALUOp)
            c_op_add: begin alu_ctrl = c_ctrl_add; is_basic = 1'b1; end
            c_op_sub: begin alu_ctrl = c_ctrl_sub; is_basic = 1'b1; end
            c_op_or:  begin alu_ctrl = c_ctrl_or;  is_basic = 1'b1; end
            default: begin
                case (funct)
                    c_fn_add:   begin alu_ctrl = c_ctrl_add; is_basic = 1'b1; end
                    c_fn_sub:   begin alu_ctrl = c_ctrl_sub; is_basic = 1'b1; end
                    c_fn_and:   begin alu_ctrl = c_ctrl_and; is_basic = 1'b1; end
                    c_fn_or:    begin alu_ctrl = c_ctrl_or;  is_basic = 1'b1; end
                    c_fn_nor:   begin alu_ctrl = c_ctrl_nor; is_basic = 1'b1; end
                    c_fn_slt:   begin alu_ctrl = c_ctrl_slt; is_basic = 1'b1; end
                    c_fn_mfhi:  is_mfhi = 1'b1;
                    c_fn_mflo:  is_mflo = 1'b1;
                    c_fn_mult:  begin is_mul = 1'b1; is_signed = 1'b1; end
                    c_fn_multu: is_mul = 1'b1;
                    c_fn_div:   begin is_div = 1'b1; is_signed = 1'b1; end
                    c_fn_divu:  is_div = 1'b1;
                    default:    is_illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_unit
//  Description : Execute-stage ALU with registered single-cycle ops plus an
//                iterative shift-add multiplier / restoring divider feeding
//                HI/LO. Start/busy/done handshake.
//                Build option ALU_MULDIV_SIGNED_EN: signed mult/div with a
//                sign fix-up (FIX) state; otherwise mult/div act as
//                multu/divu and HI/LO are written on the last RUN step.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             illegal
);
    import alu_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
`ifdef ALU_MULDIV_SIGNED_EN
    localparam logic c_signed_en = 1'b1;
`else
    localparam logic c_signed_en = 1'b0;
`endif

    logic [3:0]       w_ctrl;
    logic             w_is_basic, w_is_mfhi, w_is_mflo, w_is_mul, w_is_div;
    logic             w_is_signed, w_is_illegal;
    logic             w_accept, w_iter_start, w_last, w_sgn;
    logic [WIDTH-1:0] w_alu, w_res, w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_sum, w_rsh;
    logic             w_ge;
    logic [WIDTH-1:0] w_acc_nxt, w_mq_nxt;
    state_t           r_state, w_state_nxt;

    logic [WIDTH-1:0] r_result, r_hi, r_lo, r_acc, r_mq, r_opd, r_opa;
    logic             r_zero, r_done, r_illegal, r_is_div, r_dbz;
    logic [CW-1:0]    r_cnt;
`ifdef ALU_MULDIV_SIGNED_EN
    logic             r_neg_ab, r_neg_a;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_q_fix, w_r_fix;
`endif

    alu_ctrl_decode u_dec (
        .ALUOp      (ALUOp),
        .funct      (funct),
        .alu_ctrl   (w_ctrl),
        .is_basic   (w_is_basic),
        .is_mfhi    (w_is_mfhi),
        .is_mflo    (w_is_mflo),
        .is_mul     (w_is_mul),
        .is_div     (w_is_div),
        .is_signed  (w_is_signed),
        .is_illegal (w_is_illegal)
    );

    assign result  = r_result;
    assign zero    = r_zero;
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign done    = r_done;
    assign illegal = r_illegal;

    // Single-cycle ALU function and result selection (illegal forces zero)
    always_comb begin
        case (w_ctrl)
            c_ctrl_add: w_alu = a + b;
            c_ctrl_sub: w_alu = a - b;
            c_ctrl_and: w_alu = a & b;
            c_ctrl_or:  w_alu = a | b;
            c_ctrl_nor: w_alu = ~(a | b);
            c_ctrl_slt: w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:    w_alu = '0;
        endcase
        if (w_is_illegal)    w_res = '0;
        else if (w_is_mfhi)  w_res = r_hi;
        else if (w_is_mflo)  w_res = r_lo;
        else if (w_is_basic) w_res = w_alu;
        else                 w_res = '0;
    end

    // Operand magnitudes and one shift-add / restoring-subtract step
    always_comb begin
        w_sgn   = w_is_signed & c_signed_en;
        w_mag_a = (w_sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
        w_mag_b = (w_sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;
        w_sum   = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opd} : '0);
        w_rsh   = {r_acc, r_mq[WIDTH-1]};
        w_ge    = (w_rsh >= {1'b0, r_opd});
        if (r_is_div) begin
            w_acc_nxt = w_ge ? (w_rsh[WIDTH-1:0] - r_opd) : w_rsh[WIDTH-1:0];
            w_mq_nxt  = {r_mq[WIDTH-2:0], w_ge};
        end else begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
        end
    end

`ifdef ALU_MULDIV_SIGNED_EN
    // Sign correction applied in FIX
    always_comb begin
        w_prod_fix = r_neg_ab ? (~{r_acc, r_mq} + 1'b1) : {r_acc, r_mq};
        w_q_fix    = r_neg_ab ? (~r_mq + 1'b1) : r_mq;
        w_r_fix    = r_neg_a  ? (~r_acc + 1'b1) : r_acc;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_iter_start) w_state_nxt = RUN;
`ifdef ALU_MULDIV_SIGNED_EN
            RUN:  if (w_last) w_state_nxt = FIX;
            FIX:  w_state_nxt = IDLE;
`else
            RUN:  if (w_last) w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy, request acceptance, last iteration marker
    always_comb begin
        busy         = (r_state != IDLE);
        w_accept     = start & (r_state == IDLE);
        w_iter_start = w_accept & (w_is_mul | w_is_div);
        w_last       = (r_state == RUN) && (r_cnt == c_last);
    end

    // Datapath: result/flags, iterative engine registers, HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_opd     <= '0;
            r_opa     <= '0;
            r_is_div  <= 1'b0;
            r_dbz     <= 1'b0;
            r_cnt     <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
            r_neg_ab  <= 1'b0;
            r_neg_a   <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            if (w_iter_start) begin
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mq     <= w_mag_a;
                r_opd    <= w_mag_b;
                r_opa    <= a;
                r_is_div <= w_is_div;
                r_dbz    <= (b == '0);
`ifdef ALU_MULDIV_SIGNED_EN
                r_neg_ab <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_a  <= w_sgn & a[WIDTH-1];
`endif
            end else if (w_accept) begin
                r_result  <= w_res;
                r_zero    <= (w_res == '0);
                r_done    <= 1'b1;
                r_illegal <= w_is_illegal;
            end
            if (r_state == RUN) begin
                r_cnt <= r_cnt + CW'(1);
                r_acc <= w_acc_nxt;
                r_mq  <= w_mq_nxt;
`ifndef ALU_MULDIV_SIGNED_EN
                if (w_last) begin
                    r_done <= 1'b1;
                    if (r_is_div && r_dbz) begin
                        r_hi <= r_opa;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_acc_nxt;
                        r_lo <= w_mq_nxt;
                    end
                end
`endif
            end
`ifdef ALU_MULDIV_SIGNED_EN
            if (r_state == FIX) begin
                r_done <= 1'b1;
                if (r_is_div && r_dbz) begin
                    r_hi <= r_opa;
                    r_lo <= '1;
                end else if (r_is_div) begin
                    r_hi <= w_r_fix;
                    r_lo <= w_q_fix;
                end else begin
                    {r_hi, r_lo} <= w_prod_fix;
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_unit
//  Description : Self-checking bench for alu_muldiv_unit: table of single-
//                cycle vectors plus hand-written mult/div, busy-ignore and
//                mid-run reset sequences. Honours ALU_MULDIV_SIGNED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_unit;

    localparam int W = 32;
`ifdef ALU_MULDIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   ALUOp;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic [W-1:0] result, hi, lo;
    logic         zero, busy, done, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] res;
        logic         z;
        logic         ill;
    } vec_t;

    vec_t vecs [13];

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ALUOp   (ALUOp),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .result  (result),
        .zero    (zero),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        ALUOp = v.op; funct = v.fn; a = v.va; b = v.vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d.result", idx), result, v.res);
        chk($sformatf("v%0d.zero", idx), W'(zero), W'(v.z));
        chk($sformatf("v%0d.done", idx), W'(done), W'(1));
        chk($sformatf("v%0d.illegal", idx), W'(illegal), W'(v.ill));
        @(posedge clk); #1;
        chk($sformatf("v%0d.done_drop", idx), W'(done), W'(0));
    endtask

    // Launch a mult/div, wait for done, check latency/HI/LO, then mflo in the done cycle
    task automatic run_iter(input string name, input logic [5:0] fn,
                            input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int got;
        logic busy_ok;
        got = 0; busy_ok = 1'b1;
        ALUOp = 2'b10; funct = fn; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= LAT + 20; n++) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (done) begin got = n; break; end
        end
        chk({name, ".latency"}, W'(got), W'(LAT));
        chk({name, ".busy_held"}, W'(busy_ok), W'(1));
        chk({name, ".busy_clr"}, W'(busy), W'(0));
        chk({name, ".hi"}, hi, ehi);
        chk({name, ".lo"}, lo, elo);
        funct = 6'b010010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, ".mflo"}, result, elo);
        chk({name, ".mflo_done"}, W'(done), W'(1));
    endtask

    initial begin
        logic [W-1:0] res_before;
        int ndone;

        vecs[0]  = '{2'b10, 6'b100000, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0};
        vecs[2]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[3]  = '{2'b10, 6'b101010, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
        vecs[4]  = '{2'b00, 6'b111111, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
        vecs[5]  = '{2'b11, 6'b000000, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0};
        vecs[6]  = '{2'b10, 6'b100010, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 6'b100111, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 6'b111111, 32'd5,        32'd6,        32'd0,        1'b1, 1'b1};
        vecs[10] = '{2'b10, 6'b010000, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0};
        vecs[11] = '{2'b10, 6'b100101, 32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0};
        vecs[12] = '{2'b00, 6'b111111, 32'd2,        32'd3,        32'd5,        1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; ALUOp = 2'b00; funct = 6'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.result", result, 32'd0);
        chk("rst.zero", W'(zero), W'(1));
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.busy", W'(busy), W'(0));
        chk("rst.done", W'(done), W'(0));
        chk("rst.illegal", W'(illegal), W'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) apply(vecs[i], i);

`ifdef ALU_MULDIV_SIGNED_EN
        run_iter("mult_m3x7", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_iter("div_m7d2",  6'b011010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_iter("div_7dm2",  6'b011010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
`else
        run_iter("mult_m3x7", 6'b011000, 32'hFFFFFFFD, 32'd7, 32'd6, 32'hFFFFFFEB);
        run_iter("div_m7d2",  6'b011010, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC);
        run_iter("div_7dm2",  6'b011010, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0);
`endif
        run_iter("divu_100d7", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_iter("div_9d0",    6'b011010, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
        run_iter("multu_max",  6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1);

        // mfhi right after a completed mult returns the new HI
        ALUOp = 2'b10; funct = 6'b010000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mfhi_after", result, 32'hFFFFFFFE);

        // start during RUN is ignored: exactly one done, result untouched
        @(posedge clk); #1;
        res_before = result;
        ndone = 0;
        ALUOp = 2'b10; funct = 6'b011001; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= LAT + 3; n++) begin
            if (n == 4) begin ALUOp = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) ndone++;
        end
        start = 1'b0;
        chk("ignore.ndone", W'(ndone), W'(1));
        chk("ignore.result", result, res_before);
        chk("ignore.lo", lo, 32'd15);

        // reset at RUN cycle 10 aborts: HI/LO cleared, no done afterwards
        ALUOp = 2'b10; funct = 6'b011000; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("abort.busy", W'(busy), W'(0));
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        chk("abort.done", W'(done), W'(0));
        @(posedge clk); #3;
        reset = 1'b0;
        ndone = 0;
        for (int n = 0; n < LAT + 3; n++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("abort.quiet", W'(ndone), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
